// File: rtl/keypad_saw_synth.sv
// ---------------------------------------------------------------------------
// keypad_saw_synth
//
// Keypad-driven sawtooth tone generator. One key of a 4x4 matrix keypad is
// decoded to a hex code, the code selects one of 16 note frequencies, and a
// phase accumulator stepped by that note's increment drives a rising
// sawtooth ramp. One signed sample is produced per sample clock.
//
// Ports
//   clk_i        sample clock, all state changes on its rising edge
//   reset_ni     asynchronous active-low reset
//   kpyd_i       {row[3:0], col[3:0]}, active-high; bit 4 = row 0, bit 0 = col 0
//   hex_o        registered key code (holds its value when no valid key)
//   key_valid_o  registered, 1 while exactly one row and one column are active
//   phase_inc_o  phase increment of the current note (combinational from hex_o)
//   addr_o       top ADDR_WIDTH_P bits of the phase accumulator
//   data_o       registered signed sawtooth sample, zero while no key is held
//   valid_o      registered, 1 from the first clock after reset release
// ---------------------------------------------------------------------------
module keypad_saw_synth #(
    parameter int ACC_WIDTH_P   = 32,
    parameter int ADDR_WIDTH_P  = 10,
    parameter int WIDTH_P       = 24,
    parameter int SAMPLE_RATE_P = 48000
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [7:0]              kpyd_i,
    output logic [3:0]              hex_o,
    output logic                    key_valid_o,
    output logic [ACC_WIDTH_P-1:0]  phase_inc_o,
    output logic [ADDR_WIDTH_P-1:0] addr_o,
    output logic [WIDTH_P-1:0]      data_o,
    output logic                    valid_o
);

    // floor(f * 2^ACC_WIDTH_P / SAMPLE_RATE_P), evaluated only on constants.
    function automatic logic [ACC_WIDTH_P-1:0] calc_inc(input logic [63:0] freq_hz);
        logic [63:0] scaled;
        scaled = (freq_hz << ACC_WIDTH_P) / 64'(SAMPLE_RATE_P);
        return scaled[ACC_WIDTH_P-1:0];
    endfunction

    localparam logic [ACC_WIDTH_P-1:0] INC_0 = calc_inc(64'd261);
    localparam logic [ACC_WIDTH_P-1:0] INC_1 = calc_inc(64'd294);
    localparam logic [ACC_WIDTH_P-1:0] INC_2 = calc_inc(64'd330);
    localparam logic [ACC_WIDTH_P-1:0] INC_3 = calc_inc(64'd349);
    localparam logic [ACC_WIDTH_P-1:0] INC_4 = calc_inc(64'd392);
    localparam logic [ACC_WIDTH_P-1:0] INC_5 = calc_inc(64'd440);
    localparam logic [ACC_WIDTH_P-1:0] INC_6 = calc_inc(64'd494);
    localparam logic [ACC_WIDTH_P-1:0] INC_7 = calc_inc(64'd523);
    localparam logic [ACC_WIDTH_P-1:0] INC_8 = calc_inc(64'd587);
    localparam logic [ACC_WIDTH_P-1:0] INC_9 = calc_inc(64'd659);
    localparam logic [ACC_WIDTH_P-1:0] INC_A = calc_inc(64'd698);
    localparam logic [ACC_WIDTH_P-1:0] INC_B = calc_inc(64'd784);
    localparam logic [ACC_WIDTH_P-1:0] INC_C = calc_inc(64'd880);
    localparam logic [ACC_WIDTH_P-1:0] INC_D = calc_inc(64'd988);
    localparam logic [ACC_WIDTH_P-1:0] INC_E = calc_inc(64'd1046);
    localparam logic [ACC_WIDTH_P-1:0] INC_F = calc_inc(64'd1174);

    localparam int PAD_W = WIDTH_P - ADDR_WIDTH_P;

    logic [3:0]              hex_q, hex_d;
    logic                    key_valid_q, key_valid_d;
    logic [ACC_WIDTH_P-1:0]  acc_q, acc_d;
    logic [WIDTH_P-1:0]      data_q, data_d;
    logic                    valid_q;

    logic                    key_hit;
    logic [3:0]              key_code;
    logic [ACC_WIDTH_P-1:0]  phase_inc;
    logic [ADDR_WIDTH_P-1:0] addr;
    logic [WIDTH_P-1:0]      saw;

    // Only the 16 exact one-row/one-column patterns are keys; anything else
    // (nothing pressed, ghosting, multiple keys) is rejected.
    always_comb begin
        key_hit  = 1'b1;
        key_code = 4'h0;
        case (kpyd_i)
            8'b0001_0001: key_code = 4'h1;
            8'b0001_0010: key_code = 4'h2;
            8'b0001_0100: key_code = 4'h3;
            8'b0001_1000: key_code = 4'hA;
            8'b0010_0001: key_code = 4'h4;
            8'b0010_0010: key_code = 4'h5;
            8'b0010_0100: key_code = 4'h6;
            8'b0010_1000: key_code = 4'hB;
            8'b0100_0001: key_code = 4'h7;
            8'b0100_0010: key_code = 4'h8;
            8'b0100_0100: key_code = 4'h9;
            8'b0100_1000: key_code = 4'hC;
            8'b1000_0001: key_code = 4'hE;
            8'b1000_0010: key_code = 4'h0;
            8'b1000_0100: key_code = 4'hF;
            8'b1000_1000: key_code = 4'hD;
            default:      key_hit  = 1'b0;
        endcase
    end

    always_comb begin
        phase_inc = INC_0;
        case (hex_q)
            4'h0: phase_inc = INC_0;
            4'h1: phase_inc = INC_1;
            4'h2: phase_inc = INC_2;
            4'h3: phase_inc = INC_3;
            4'h4: phase_inc = INC_4;
            4'h5: phase_inc = INC_5;
            4'h6: phase_inc = INC_6;
            4'h7: phase_inc = INC_7;
            4'h8: phase_inc = INC_8;
            4'h9: phase_inc = INC_9;
            4'hA: phase_inc = INC_A;
            4'hB: phase_inc = INC_B;
            4'hC: phase_inc = INC_C;
            4'hD: phase_inc = INC_D;
            4'hE: phase_inc = INC_E;
            4'hF: phase_inc = INC_F;
            default: phase_inc = INC_0;
        endcase
    end

    assign addr = acc_q[ACC_WIDTH_P-1 -: ADDR_WIDTH_P];

    // addr * 2^PAD_W - 2^(WIDTH_P-1): flipping the address MSB turns the
    // unsigned ramp into a signed one centred on zero.
    assign saw = {~addr[ADDR_WIDTH_P-1], addr[ADDR_WIDTH_P-2:0], {PAD_W{1'b0}}};

    always_comb begin
        hex_d       = key_hit ? key_code : hex_q;
        key_valid_d = key_hit;
        // Accumulator free-runs so phase stays continuous across key changes.
        acc_d       = acc_q + phase_inc;
        data_d      = key_valid_q ? saw : '0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hex_q       <= 4'h0;
            key_valid_q <= 1'b0;
            acc_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            hex_q       <= hex_d;
            key_valid_q <= key_valid_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            valid_q     <= 1'b1;
        end
    end

    assign hex_o       = hex_q;
    assign key_valid_o = key_valid_q;
    assign phase_inc_o = phase_inc;
    assign addr_o      = addr;
    assign data_o      = data_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_keypad_saw_synth.sv
module tb_keypad_saw_synth;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic [7:0]  kpyd_i;
    logic [3:0]  hex_o;
    logic        key_valid_o;
    logic [31:0] phase_inc_o;
    logic [9:0]  addr_o;
    logic [23:0] data_o;
    logic        valid_o;

    always #5 clk_i = ~clk_i;

    keypad_saw_synth dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .kpyd_i      (kpyd_i),
        .hex_o       (hex_o),
        .key_valid_o (key_valid_o),
        .phase_inc_o (phase_inc_o),
        .addr_o      (addr_o),
        .data_o      (data_o),
        .valid_o     (valid_o)
    );

    int n_vec = 0;
    int n_err = 0;

    int freq_tab [16] = '{261, 294, 330, 349, 392, 440, 494, 523,
                          587, 659, 698, 784, 880, 988, 1046, 1174};
    // key code by row*4 + col
    int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    logic [31:0] acc_m;
    logic [3:0]  hex_m;
    logic        kv_m;
    logic [23:0] data_m;
    logic        valid_m;

    typedef struct {
        logic [7:0] kpyd;
        logic [3:0] hex;
        logic       kv;
    } vec_t;
    vec_t vecs [21];

    function automatic logic [31:0] exp_inc(input logic [3:0] h);
        logic [63:0] t;
        t = (64'(freq_tab[h]) << 32) / 64'd48000;
        return t[31:0];
    endfunction

    function automatic logic [23:0] saw_m(input logic [9:0] a);
        int v;
        v = (int'(a) - 512) * 16384;
        return v[23:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        acc_m = 0; hex_m = 0; kv_m = 0; data_m = 0; valid_m = 0;
    endtask

    task automatic model_step();
        logic [23:0] d_n;
        logic [31:0] a_n;
        int r, c;
        d_n = kv_m ? saw_m(acc_m[31:22]) : 24'd0;
        a_n = acc_m + exp_inc(hex_m);
        if ($countones(kpyd_i[7:4]) == 1 && $countones(kpyd_i[3:0]) == 1) begin
            r = 0; c = 0;
            for (int i = 0; i < 4; i++) begin
                if (kpyd_i[4+i]) r = i;
                if (kpyd_i[i])   c = i;
            end
            hex_m = 4'(layout[r*4+c]);
            kv_m  = 1'b1;
        end else begin
            kv_m = 1'b0;
        end
        acc_m   = a_n;
        data_m  = d_n;
        valid_m = 1'b1;
    endtask

    task automatic cycle();
        @(posedge clk_i);
        if (reset_ni) model_step();
        @(negedge clk_i);
        chk("addr",  addr_o,      acc_m[31:22]);
        chk("data",  data_o,      data_m);
        chk("valid", valid_o,     valid_m);
        chk("hex",   hex_o,       hex_m);
        chk("kv",    key_valid_o, kv_m);
    endtask

    initial begin
        logic signed [23:0] d_s;
        int prev, cur, wraps;

        vecs[0]  = '{8'h11, 4'h1, 1'b1};
        vecs[1]  = '{8'h12, 4'h2, 1'b1};
        vecs[2]  = '{8'h14, 4'h3, 1'b1};
        vecs[3]  = '{8'h18, 4'hA, 1'b1};
        vecs[4]  = '{8'h21, 4'h4, 1'b1};
        vecs[5]  = '{8'h22, 4'h5, 1'b1};
        vecs[6]  = '{8'h24, 4'h6, 1'b1};
        vecs[7]  = '{8'h28, 4'hB, 1'b1};
        vecs[8]  = '{8'h41, 4'h7, 1'b1};
        vecs[9]  = '{8'h42, 4'h8, 1'b1};
        vecs[10] = '{8'h44, 4'h9, 1'b1};
        vecs[11] = '{8'h48, 4'hC, 1'b1};
        vecs[12] = '{8'h81, 4'hE, 1'b1};
        vecs[13] = '{8'h82, 4'h0, 1'b1};
        vecs[14] = '{8'h84, 4'hF, 1'b1};
        vecs[15] = '{8'h88, 4'hD, 1'b1};
        vecs[16] = '{8'h33, 4'hD, 1'b0};
        vecs[17] = '{8'h00, 4'hD, 1'b0};
        vecs[18] = '{8'hF1, 4'hD, 1'b0};
        vecs[19] = '{8'h1F, 4'hD, 1'b0};
        vecs[20] = '{8'h42, 4'h8, 1'b1};

        // Reset held for 3 cycles, then released with no key
        kpyd_i   = 8'h00;
        reset_ni = 1'b1;
        model_reset();
        #1 reset_ni = 1'b0;
        repeat (3) cycle();
        chk("rst_inc", phase_inc_o, 32'd23353884);
        chk("rst_valid", valid_o, 1'b0);
        reset_ni = 1'b1;
        cycle();
        chk("valid_after_release", valid_o, 1'b1);
        chk("hex_after_release", hex_o, 4'h0);
        chk("data_after_release", data_o, 24'h0);

        // Key 5 held for a run of samples
        kpyd_i = 8'h22;
        cycle();
        chk("key5_hex", hex_o, 4'h5);
        chk("key5_kv", key_valid_o, 1'b1);
        chk("key5_inc", phase_inc_o, 32'd39370533);
        repeat (20) cycle();

        // Decode sweep plus rejected patterns
        foreach (vecs[i]) begin
            kpyd_i = vecs[i].kpyd;
            cycle();
            chk($sformatf("sweep%0d_hex", i), hex_o, vecs[i].hex);
            chk($sformatf("sweep%0d_kv", i), key_valid_o, vecs[i].kv);
            chk($sformatf("sweep%0d_inc", i), phase_inc_o, exp_inc(vecs[i].hex));
        end
        kpyd_i = 8'h84;
        cycle();
        chk("incF", phase_inc_o, 32'd105047741);

        // Invalid key after key 9
        kpyd_i = 8'h44;
        cycle();
        chk("key9_hex", hex_o, 4'h9);
        kpyd_i = 8'h33;
        cycle();
        chk("inv33_hex", hex_o, 4'h9);
        chk("inv33_kv", key_valid_o, 1'b0);
        cycle();
        chk("inv33_data", data_o, 24'h0);
        kpyd_i = 8'h00;
        cycle();
        chk("none_hex", hex_o, 4'h9);
        chk("none_kv", key_valid_o, 1'b0);
        chk("none_data", data_o, 24'h0);

        // Wrap-around with key F: ~25 addresses per sample
        kpyd_i = 8'h84;
        cycle();
        cycle();
        d_s   = data_o;
        prev  = int'(d_s);
        wraps = 0;
        repeat (409) begin
            cycle();
            d_s = data_o;
            cur = int'(d_s);
            if (cur < prev) begin
                wraps++;
                chk("wrap_top", prev >= 7929856, 1'b1);
                chk("wrap_bottom", cur <= -7962624, 1'b1);
            end else begin
                chk("ramp_rising", cur > prev, 1'b1);
            end
            prev = cur;
        end
        chk("wrap_count_ok", (wraps >= 10) && (wraps <= 11), 1'b1);

        // Asynchronous reset between edges
        repeat (5) cycle();
        @(posedge clk_i);
        model_step();
        #2 reset_ni = 1'b0;
        model_reset();
        #1;
        chk("arst_hex", hex_o, 4'h0);
        chk("arst_kv", key_valid_o, 1'b0);
        chk("arst_addr", addr_o, 10'd0);
        chk("arst_data", data_o, 24'h0);
        chk("arst_valid", valid_o, 1'b0);
        chk("arst_inc", phase_inc_o, 32'd23353884);
        @(negedge clk_i);
        kpyd_i = 8'h22;
        repeat (2) cycle();
        reset_ni = 1'b1;
        cycle();
        chk("restart_addr1", addr_o, 10'd5);
        chk("restart_hex", hex_o, 4'h5);
        cycle();
        chk("restart_addr2", addr_o, 10'd14);
        chk("restart_data", data_o, 24'h814000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
